infix_token_tx: RTL and testbench

- Transmit side of the converter's token-input interface: buffers one infix expression (numbers and operator signs), then plays it out token by token on the sign/number strobe interface.
- Honours the consumer's BUSY back-pressure.
- Closes each expression with the end marker (both strobes high together).
- Sits in front of conv; replaces file-driven stimulus for on-chip or host-loaded expressions.

---
 rtl/infix_token_tx.sv | 154 +++++++++++++++
 tb/tb_infix_token_tx.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/infix_token_tx.sv
// Token-input transmitter: buffers one infix expression and plays it out on the
// sign/number strobe interface, honouring consumer BUSY and closing with an end marker.
module infix_token_tx #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          WR_EN,
  input  logic          WR_IS_SIGN,
  input  logic [7:0]    WR_DATA,
  output logic          WR_FULL,
  output logic          WR_ERR,
  input  logic          START,
  input  logic          BUSY_IN,
  output logic [7:0]    SIGN_OUT,
  output logic          SIGN_OUT_STB,
  output logic [7:0]    NUMBER_OUT,
  output logic          NUMBER_OUT_STB,
  output logic          TX_ACTIVE,
  output logic          DONE,
  output logic [AW:0]   SENT_CNT
);

  typedef enum logic [2:0] {IDLE, WAIT_FREE, STROBE, END_WAIT, END_STROBE} state_t;

  typedef struct packed {
    logic       is_sign;
    logic [7:0] data;
  } token_t;

  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];
  localparam logic [AW:0] ONE      = (AW+1)'(1);

  token_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count, count_nx;
  state_t        state, state_nx;

  logic   sign_ok, is_full, is_empty, wr_rej, push, pop;
  token_t head;

  assign sign_ok  = (WR_DATA == 8'h2B) || (WR_DATA == 8'h2D) ||
                    (WR_DATA == 8'h2A) || (WR_DATA == 8'h2F);
  assign is_full  = (count == FULL_CNT);
  assign is_empty = (count == '0);
  assign wr_rej   = WR_EN && (is_full || (state != IDLE) || (WR_IS_SIGN && !sign_ok));
  assign push     = WR_EN && !wr_rej;
  assign head     = mem[rd_ptr];

  // Payload storage needs no reset: validity is carried by the pointers and count.
  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= '{is_sign: WR_IS_SIGN, data: WR_DATA};
  end

  always_comb begin
    count_nx = count;
    if (push)     count_nx = count + ONE;
    else if (pop) count_nx = count - ONE;
  end

  always_comb begin
    state_nx = state;
    pop      = 1'b0;
    case (state)
      IDLE:       if (START) state_nx = WAIT_FREE;
      WAIT_FREE: begin
        // An empty buffer with a free consumer goes straight to the end marker,
        // so an empty run strobes one edge after START just like a token would.
        if (is_empty)      state_nx = BUSY_IN ? END_WAIT : END_STROBE;
        else if (!BUSY_IN) begin
          pop      = 1'b1;
          state_nx = STROBE;
        end
      end
      STROBE:     if (BUSY_IN)  state_nx = WAIT_FREE;
      END_WAIT:   if (!BUSY_IN) state_nx = END_STROBE;
      END_STROBE: if (BUSY_IN)  state_nx = IDLE;
      default:    state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state          <= IDLE;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      WR_FULL        <= 1'b0;
      WR_ERR         <= 1'b0;
      SIGN_OUT       <= '0;
      SIGN_OUT_STB   <= 1'b0;
      NUMBER_OUT     <= '0;
      NUMBER_OUT_STB <= 1'b0;
      TX_ACTIVE      <= 1'b0;
      DONE           <= 1'b0;
      SENT_CNT       <= '0;
    end else begin
      state   <= state_nx;
      count   <= count_nx;
      WR_FULL <= (count_nx == FULL_CNT);
      WR_ERR  <= wr_rej;
      DONE    <= 1'b0;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;

      case (state)
        IDLE: begin
          if (START) begin
            TX_ACTIVE <= 1'b1;
            SENT_CNT  <= '0;
          end
        end
        WAIT_FREE: begin
          if (pop) begin
            if (head.is_sign) begin
              SIGN_OUT     <= head.data;
              SIGN_OUT_STB <= 1'b1;
            end else begin
              NUMBER_OUT     <= head.data;
              NUMBER_OUT_STB <= 1'b1;
            end
          end else if (state_nx == END_STROBE) begin
            SIGN_OUT_STB   <= 1'b1;
            NUMBER_OUT_STB <= 1'b1;
          end
        end
        STROBE: begin
          if (BUSY_IN) begin
            SIGN_OUT_STB   <= 1'b0;
            NUMBER_OUT_STB <= 1'b0;
            SENT_CNT       <= SENT_CNT + ONE;
          end
        end
        END_WAIT: begin
          if (!BUSY_IN) begin
            SIGN_OUT_STB   <= 1'b1;
            NUMBER_OUT_STB <= 1'b1;
          end
        end
        END_STROBE: begin
          if (BUSY_IN) begin
            SIGN_OUT_STB   <= 1'b0;
            NUMBER_OUT_STB <= 1'b0;
            DONE           <= 1'b1;
            TX_ACTIVE      <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_infix_token_tx.sv
// Randomized bench for infix_token_tx: a queue model of the token buffer plus a
// BUSY-driving consumer and a strobe monitor that records the played-out stream.
module tb_infix_token_tx;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          WR_EN = 1'b0, WR_IS_SIGN = 1'b0, START = 1'b0, BUSY_IN = 1'b0;
  logic [7:0]    WR_DATA = 8'h00;
  logic          WR_FULL, WR_ERR, SIGN_OUT_STB, NUMBER_OUT_STB, TX_ACTIVE, DONE;
  logic [7:0]    SIGN_OUT, NUMBER_OUT;
  logic [AW:0]   SENT_CNT;

  infix_token_tx #(.DEPTH(DEPTH), .AW(AW)) dut (
    .CLK(CLK), .RST(RST), .WR_EN(WR_EN), .WR_IS_SIGN(WR_IS_SIGN), .WR_DATA(WR_DATA),
    .WR_FULL(WR_FULL), .WR_ERR(WR_ERR), .START(START), .BUSY_IN(BUSY_IN),
    .SIGN_OUT(SIGN_OUT), .SIGN_OUT_STB(SIGN_OUT_STB), .NUMBER_OUT(NUMBER_OUT),
    .NUMBER_OUT_STB(NUMBER_OUT_STB), .TX_ACTIVE(TX_ACTIVE), .DONE(DONE), .SENT_CNT(SENT_CNT)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Consumer: raises BUSY the cycle after it sees a strobe, holds it, then drops it.
  bit auto_busy = 1'b0, busy_force = 1'b0;
  int hold_fix = 2, hold_left = 0;
  initial forever begin
    @(posedge CLK); #2;
    if (!auto_busy) BUSY_IN = busy_force;
    else if (!BUSY_IN && (SIGN_OUT_STB || NUMBER_OUT_STB)) begin
      BUSY_IN   = 1'b1;
      hold_left = (hold_fix >= 0) ? hold_fix : int'($urandom_range(0, 3));
    end else if (BUSY_IN) begin
      if (hold_left <= 0) BUSY_IN = 1'b0;
      else hold_left--;
    end
  end

  // Monitor: one record per strobe rise; counts end markers, DONE pulses and
  // any strobe that rose on an edge that sampled BUSY high.
  logic [8:0] obs_q[$];
  int  end_cnt = 0, done_cnt = 0, viol = 0;
  logic prev_any = 1'b0, busy_smp = 1'b0;
  always @(posedge CLK) busy_smp <= BUSY_IN;
  always @(negedge CLK) begin
    if (RST) prev_any = 1'b0;
    else begin
      if ((SIGN_OUT_STB || NUMBER_OUT_STB) && !prev_any) begin
        if (busy_smp) viol++;
        if (SIGN_OUT_STB && NUMBER_OUT_STB) end_cnt++;
        else obs_q.push_back(SIGN_OUT_STB ? {1'b1, SIGN_OUT} : {1'b0, NUMBER_OUT});
      end
      if (DONE) done_cnt++;
      prev_any = SIGN_OUT_STB || NUMBER_OUT_STB;
    end
  end

  logic [8:0] mdl_q[$];  // model of the buffer contents

  task automatic wr(input logic s, input logic [7:0] d, input bit in_run);
    bit valid, exp_err;
    valid   = !s || (d == 8'h2B) || (d == 8'h2D) || (d == 8'h2A) || (d == 8'h2F);
    exp_err = (mdl_q.size() == DEPTH) || in_run || !valid;
    WR_EN = 1'b1; WR_IS_SIGN = s; WR_DATA = d;
    @(posedge CLK); #1;
    WR_EN = 1'b0;
    if (!exp_err) mdl_q.push_back({s, d});
    chk("wr_err", WR_ERR, exp_err);
    chk("wr_full", WR_FULL, mdl_q.size() == DEPTH);
  endtask

  task automatic wait_busy_low();
    for (int i = 0; i < 12 && BUSY_IN; i++) begin @(posedge CLK); #1; end
    chk("busy_idle", BUSY_IN, 0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk(tag, {WR_FULL, WR_ERR, SIGN_OUT, SIGN_OUT_STB, NUMBER_OUT, NUMBER_OUT_STB,
              TX_ACTIVE, DONE, SENT_CNT}, 0);
  endtask

  task automatic run(input int budget, input bit chk_lat, input int stall);
    logic [8:0] exp_q[$];
    int ob, eb, db, rises;
    bit got;
    exp_q = mdl_q;
    ob = obs_q.size(); eb = end_cnt; db = done_cnt;
    START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    chk("tx_active", TX_ACTIVE, 1);
    chk("sent_cnt0", SENT_CNT, 0);
    if (chk_lat) begin
      @(posedge CLK); #1;
      if (exp_q.size() == 0) chk("lat_end", {SIGN_OUT_STB, NUMBER_OUT_STB}, 2'b11);
      else chk("lat_tok", {SIGN_OUT_STB, NUMBER_OUT_STB}, exp_q[0][8] ? 2'b10 : 2'b01);
    end
    if (stall > 0) begin
      rises = 0;
      for (int i = 0; i < stall; i++) begin
        @(posedge CLK); #1;
        if (SIGN_OUT_STB || NUMBER_OUT_STB) rises++;
      end
      chk("stall_no_stb", rises, 0);
      wr(1'b0, 8'h55, 1'b1);
      auto_busy = 1'b1;
    end
    got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      @(posedge CLK); #1;
      if (DONE) got = 1'b1;
    end
    chk("done_seen", got, 1);
    @(negedge CLK); #1;
    mdl_q.delete();
    chk("tx_idle", TX_ACTIVE, 0);
    chk("sent_cnt", SENT_CNT, exp_q.size());
    chk("tok_count", obs_q.size() - ob, exp_q.size());
    for (int i = 0; i < exp_q.size() && (ob + i) < obs_q.size(); i++)
      chk($sformatf("tok%0d", i), obs_q[ob + i], exp_q[i]);
    chk("end_marker", end_cnt - eb, 1);
    chk("done_once", done_cnt - db, 1);
    wait_busy_low();
  endtask

  initial begin
    int len, ob;
    bit hit;
    logic [7:0] d;
    logic s;

    repeat (2) @(posedge CLK);
    #1 chk_all_zero("rst_hold");
    RST = 1'b0;
    @(posedge CLK); #1 chk_all_zero("rst_after");

    // Expression 3 + 4 * 2, consumer holds BUSY three edges
    auto_busy = 1'b1; hold_fix = 2;
    wr(0, 8'd3, 0); wr(1, 8'h2B, 0); wr(0, 8'd4, 0); wr(1, 8'h2A, 0); wr(0, 8'd2, 0);
    run(300, 1, 0);

    // Empty buffer: end marker only
    run(50, 1, 0);

    // Overfill: 16 accepted, 17th rejected
    for (int i = 0; i < 17; i++) wr(0, 8'(i + 100), 0);
    hold_fix = 0;
    run(400, 1, 0);

    // Illegal sign, then BUSY held across START and WAIT_FREE with a write mid-run
    wr(1, 8'h25, 0);
    wr(0, 8'd3, 0); wr(1, 8'h2D, 0); wr(0, 8'd7, 0);
    auto_busy = 1'b0; busy_force = 1'b1;
    repeat (20) @(posedge CLK);
    #1 chk("pre_start_no_stb", {SIGN_OUT_STB, NUMBER_OUT_STB}, 0);
    hold_fix = 1;
    run(300, 0, 20);
    busy_force = 1'b0;

    // Reset while the third token is strobing
    for (int i = 0; i < 5; i++) wr(0, 8'(10 + i), 0);
    START = 1'b1; @(posedge CLK); #1 START = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 200 && !hit; i++) begin
      @(posedge CLK); #1;
      if (SENT_CNT == 2 && NUMBER_OUT_STB) hit = 1'b1;
    end
    chk("reach_tok3", hit, 1);
    #2 RST = 1'b1;
    #1 chk_all_zero("rst_mid");
    mdl_q.delete();
    @(posedge CLK); #1 RST = 1'b0;
    @(posedge CLK); #1;
    chk("rst_tx_idle", TX_ACTIVE, 0);
    chk("rst_not_full", WR_FULL, 0);
    wait_busy_low();
    run(50, 1, 0);

    // Random expressions with random consumer hold times
    hold_fix = -1;
    for (int r = 0; r < 8; r++) begin
      len = $urandom_range(0, 18);
      for (int i = 0; i < len; i++) begin
        s = ($urandom_range(0, 2) == 0);
        if (!s) d = 8'($urandom_range(0, 255));
        else case ($urandom_range(0, 4))
          0: d = 8'h2B; 1: d = 8'h2D; 2: d = 8'h2A; 3: d = 8'h2F;
          default: d = 8'h25;
        endcase
        wr(s, d, 0);
      end
      run(800, 1, 0);
    end

    chk("busy_rise_viol", viol, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
